// File: rtl/ps2_pkg.sv
// Purpose: shared types and constants for the PS/2 keyboard receiver.
// Latency: none (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    // Scan-code prefixes that modify the following key code
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

    // Frame deserialiser states
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    // One buffered key event, 10 bits: {extended, released, code}
    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } key_evt_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: synchronise raw PS/2 clock/data, debounce the clock, strobe on its falling edge.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable samples from a raw clock edge to clk_fall.
// Backpressure: none; free-running, the strobe is never held off.
// Ports: clk/rst_n system clock and async active-low reset; ps2_clk/ps2_data raw lines;
//        clk_fall one-cycle strobe; data_bit synchronised data, valid while clk_fall is high.
module ps2_line_filter #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_fall,
    output logic data_bit
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            deb_cnt   <= '0;
            clk_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_fall  <= 1'b0;
            if (clk_sync[1] != clk_filt) begin
                // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample
                if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    clk_filt <= clk_sync[1];
                    deb_cnt  <= '0;
                    // Flipping away from 1 means a falling edge
                    clk_fall <= clk_filt;
                end else begin
                    deb_cnt <= deb_cnt + CW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign data_bit = data_sync[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// Purpose: PS/2 keyboard front end: filter, 11-bit frame deserialise/check, prefix fold, event FIFO.
// Latency: event written on the edge after the stop-bit strobe; Valid rises the cycle after.
// Backpressure: Valid/Ready pop; a full FIFO drops new events and sets sticky Overflow.
// Ports: Clock, btnCpuReset (async active-low); PS2Clk/PS2Data raw inputs; Ready pops the head;
//        ScanData/Release/Extended head event (zero when empty); Valid not-empty;
//        FrameErr one-cycle pulse per discarded frame; Overflow sticky drop flag.
// Build option: define PS2_RAW_BYTES_EN to push every accepted byte (E0/F0 included) unfolded.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic       Clock,
    input  logic       btnCpuReset,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    input  logic       Ready,
    output logic [7:0] ScanData,
    output logic       Release,
    output logic       Extended,
    output logic       Valid,
    output logic       FrameErr,
    output logic       Overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          strobe;
    logic          sbit;
    ps2_state_t    state;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tmo_cnt;
    logic          acc_vld;
    logic [7:0]    acc_byte;
    logic          push_vld;
    key_evt_t      push_dat;

`ifndef PS2_RAW_BYTES_EN
    logic ext_flag;
    logic brk_flag;
`endif

    ps2_line_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .clk      (Clock),
        .rst_n    (btnCpuReset),
        .ps2_clk  (PS2Clk),
        .ps2_data (PS2Data),
        .clk_fall (strobe),
        .data_bit (sbit)
    );

    // Frame FSM, timeout and prefix tracking
    always_ff @(posedge Clock or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state    <= IDLE;
            bit_idx  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            tmo_cnt  <= '0;
            acc_vld  <= 1'b0;
            acc_byte <= '0;
            FrameErr <= 1'b0;
`ifndef PS2_RAW_BYTES_EN
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
`endif
        end else begin
            FrameErr <= 1'b0;
            acc_vld  <= 1'b0;

            if (state != IDLE && !strobe) begin
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state    <= IDLE;
                    FrameErr <= 1'b1;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end

            if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!sbit) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            FrameErr <= 1'b1;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shift in from the top
                        shreg   <= {sbit, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= ^{shreg, sbit};
                        state  <= STOP;
                    end
                    STOP: begin
                        if (sbit && par_ok) begin
                            acc_vld  <= 1'b1;
                            acc_byte <= shreg;
                        end else begin
                            FrameErr <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

`ifndef PS2_RAW_BYTES_EN
            // acc_vld and FrameErr never coincide: both follow distinct strobes
            if (acc_vld) begin
                if (acc_byte == PS2_EXT_PREFIX) begin
                    ext_flag <= 1'b1;
                end else if (acc_byte == PS2_BRK_PREFIX) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
            if (FrameErr) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
`ifdef PS2_RAW_BYTES_EN
        push_vld = acc_vld;
        push_dat = '{extended: 1'b0, released: 1'b0, code: acc_byte};
`else
        push_vld = acc_vld && (acc_byte != PS2_EXT_PREFIX) && (acc_byte != PS2_BRK_PREFIX);
        push_dat = '{extended: ext_flag, released: brk_flag, code: acc_byte};
`endif
    end

    // Event FIFO: extra pointer bit distinguishes full from empty
    key_evt_t    mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_push;
    key_evt_t    head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && Ready;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts
    assign do_push = push_vld && (!full || pop);

    always_ff @(posedge Clock or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push_vld && full && !pop) begin
                Overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Head is gated so outputs read zero whenever the FIFO is empty
    assign head     = mem[rd_ptr[AW-1:0]];
    assign Valid    = !empty;
    assign ScanData = Valid ? head.code : 8'h00;
    assign Release  = Valid && head.released;
    assign Extended = Valid && head.extended;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Purpose: randomized and directed check of ps2_key_receiver against a frame-level event model.
// Latency: n/a (bench).
// Backpressure: drives Ready directly, randomly in the soak phase.
module tb_ps2_key_receiver;

    localparam int DEB   = 8;
    localparam int DEPTH = 8;
    localparam int TMO   = 2000;
    localparam int H     = 20;

    logic       Clock = 1'b0;
    logic       btnCpuReset = 1'b0;
    logic       PS2Clk = 1'b1;
    logic       PS2Data = 1'b1;
    logic       Ready = 1'b0;
    logic [7:0] ScanData;
    logic       Release;
    logic       Extended;
    logic       Valid;
    logic       FrameErr;
    logic       Overflow;

    ps2_key_receiver #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clock       (Clock),
        .btnCpuReset (btnCpuReset),
        .PS2Clk      (PS2Clk),
        .PS2Data     (PS2Data),
        .Ready       (Ready),
        .ScanData    (ScanData),
        .Release     (Release),
        .Extended    (Extended),
        .Valid       (Valid),
        .FrameErr    (FrameErr),
        .Overflow    (Overflow)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of {ext, brk, code}, prefix state, error and overflow tallies
    logic [9:0] q[$];
    bit         m_ext = 0;
    bit         m_brk = 0;
    bit         m_ovf = 0;
    int         m_err = 0;

    function automatic void model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (q.size() >= DEPTH) m_ovf = 1;
            else q.push_back({m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    // Monitor: counts pulses and Valid cycles, checks each popped event against the model
    int         fe_cnt = 0;
    int         vld_cycles = 0;
    logic [9:0] e;

    always @(negedge Clock) begin
        if (FrameErr) fe_cnt++;
        if (Valid) vld_cycles++;
        if (Valid && Ready) begin
            check("model_has_event", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("code", ScanData, e[7:0]);
                check("release", Release, e[8]);
                check("extended", Extended, e[9]);
            end
        end
    end

    bit rdy_rand = 0;
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (rdy_rand) Ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic set_ready(input logic v);
        rdy_rand = 0;
        @(posedge Clock);
        #2;
        Ready = v;
    endtask

    task automatic send_bit(input logic v);
        PS2Data = v;
        wait_cyc(H);
        PS2Clk = 1'b0;
        wait_cyc(H);
        PS2Clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        // Model updated before the stop edge so it leads the DUT push
        model_byte(b, bad_par || bad_stop);
        send_bit(~bad_stop);
        PS2Data = 1'b1;
        wait_cyc(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         r;

        wait_cyc(3);
        check("rst_valid", Valid, 0);
        check("rst_scandata", ScanData, 0);
        check("rst_release", Release, 0);
        check("rst_extended", Extended, 0);
        check("rst_frameerr", FrameErr, 0);
        check("rst_overflow", Overflow, 0);
        btnCpuReset = 1'b1;
        wait_cyc(5);

        // Single plain key
        set_ready(1);
        vld_cycles = 0;
        send_frame(8'h1C, 0, 0);
        wait_cyc(20);
        check("t1_valid_cycles", vld_cycles, 1);
        check("t1_drained", q.size(), 0);

        // Extended release sequence yields exactly one event
        vld_cycles = 0;
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h74, 0, 0);
        wait_cyc(20);
        check("t2_valid_cycles", vld_cycles, 1);
        check("t2_drained", q.size(), 0);
        check("t2_frameerr", fe_cnt, m_err);

        // Bad parity, then recovery
        vld_cycles = 0;
        send_frame(8'h1C, 1, 0);
        wait_cyc(20);
        check("t3_frameerr", fe_cnt, m_err);
        check("t3_no_event", vld_cycles, 0);
        send_frame(8'h1B, 0, 0);
        wait_cyc(20);
        check("t3_drained", q.size(), 0);

        // Fill past capacity with consumer stalled
        set_ready(0);
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
        wait_cyc(10);
        check("t4_overflow", Overflow, m_ovf);
        check("t4_valid", Valid, 1);
        check("t4_model_depth", q.size(), DEPTH);
        set_ready(1);
        wait_cyc(30);
        check("t4_drained", q.size(), 0);
        check("t4_valid_after", Valid, 0);

        // Clock stops after 5 bits: timeout abandons the frame
        b = 8'hA5;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        PS2Data = 1'b1;
        m_err++;
        m_ext = 0;
        m_brk = 0;
        wait_cyc(TMO + 100);
        check("t5_timeout_err", fe_cnt, m_err);
        send_frame(8'h2A, 0, 0);
        wait_cyc(20);
        check("t5_drained", q.size(), 0);

        // Short clock glitch in IDLE with data high must not strobe
        vld_cycles = 0;
        PS2Data = 1'b1;
        PS2Clk = 1'b0;
        wait_cyc(DEB - 1);
        PS2Clk = 1'b1;
        wait_cyc(30);
        check("t6_no_err", fe_cnt, m_err);
        check("t6_no_event", vld_cycles, 0);
        send_frame(8'h5A, 0, 0);
        wait_cyc(20);
        check("t6_drained", q.size(), 0);

        // Randomized soak with random Ready
        rdy_rand = 1;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20)      b = 8'hE0;
            else if (r < 35) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            send_frame(b, (r >= 35 && r < 43), (r >= 43 && r < 48));
        end
        set_ready(1);
        wait_cyc(50);
        check("soak_drained", q.size(), 0);
        check("soak_frameerr", fe_cnt, m_err);
        check("soak_overflow", Overflow, m_ovf);

        // Reset mid-frame with 3 events buffered
        set_ready(0);
        send_frame(8'h11, 0, 0);
        send_frame(8'h22, 0, 0);
        send_frame(8'h33, 0, 0);
        check("t7_valid_before", Valid, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        btnCpuReset = 1'b0;
        #1;
        check("t7_valid", Valid, 0);
        check("t7_scandata", ScanData, 0);
        check("t7_release", Release, 0);
        check("t7_extended", Extended, 0);
        check("t7_overflow", Overflow, 0);
        q.delete();
        m_ovf = 0;
        m_ext = 0;
        m_brk = 0;
        PS2Clk = 1'b1;
        PS2Data = 1'b1;
        wait_cyc(3);
        btnCpuReset = 1'b1;
        wait_cyc(5);
        set_ready(1);
        vld_cycles = 0;
        send_frame(8'h44, 0, 0);
        wait_cyc(20);
        check("t7_post_valid_cycles", vld_cycles, 1);
        check("t7_drained", q.size(), 0);
        check("t7_frameerr", fe_cnt, m_err);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
